// File: rtl/shift_pkg.sv
// Shared encodings and default sizing for the multi-cycle shift unit.
package shift_pkg;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;
    localparam int DEF_STEP    = 4;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_RSVD = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response handshake bundle between the execute stage and the shift unit.
interface shift_sequencer_if
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
);
    logic               req_valid;
    logic               req_ready;
    shift_op_e          req_op;
    logic [WIDTH-1:0]   req_data;
    logic [SHAMT_W-1:0] req_shamt;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_err;

    modport master (
        output req_valid, req_op, req_data, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/shift_step.sv
// Combinational shift of WIDTH-bit data by 0..STEP bits; right shifts take
// their vacated bits from the fill input.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP,
    parameter int AMT_W = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  shift_op_e        op,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);
    always_comb begin
        result = data;
        case (op)
            SHIFT_SLL: result = data << amt;
            SHIFT_SRL,
            SHIFT_SRA: result = WIDTH'({{WIDTH{fill}}, data} >> amt);
            default:   result = data;
        endcase
    end
endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit: walks a STEP-bit shifter over the operand
// until the requested amount is consumed, then holds the result for handshake.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH            = DEF_WIDTH,
    parameter int SHAMT_W          = DEF_SHAMT_W,
    parameter int unsigned STEP    = DEF_STEP
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_sequencer_if.slave   bus,
    output logic               busy
);
    localparam int AMT_W = $clog2(STEP + 1);

    state_e             state_q, state_d;
    shift_op_e          op_q;
    logic [WIDTH-1:0]   work_q, rsp_data_q, step_out;
    logic [SHAMT_W-1:0] rem_q, rem_nxt;
    logic               fill_q, rsp_err_q;
    logic               accept, direct_done, last_step;
    logic [AMT_W-1:0]   step_amt;
    int unsigned        step_n;

    always_comb begin
        step_n    = (32'(rem_q) > STEP) ? STEP : 32'(rem_q);
        step_amt  = AMT_W'(step_n);
        rem_nxt   = rem_q - SHAMT_W'(step_n);
        last_step = (rem_nxt == '0);
    end

    shift_step #(.WIDTH(WIDTH), .STEP(STEP), .AMT_W(AMT_W)) u_step (
        .data   (work_q),
        .amt    (step_amt),
        .op     (op_q),
        .fill   (fill_q),
        .result (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        accept        = 1'b0;
        direct_done   = (bus.req_shamt == '0) || (bus.req_op == SHIFT_RSVD);
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                busy          = 1'b0;
                accept        = bus.req_valid;
                if (accept) state_d = direct_done ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: if (last_step) state_d = ST_DONE;
            ST_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers load only on entry to DONE, so they stay put through
    // backpressure and keep their value after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= SHIFT_SLL;
            work_q     <= '0;
            rem_q      <= '0;
            fill_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= bus.req_op;
            work_q <= bus.req_data;
            rem_q  <= bus.req_shamt;
            fill_q <= (bus.req_op == SHIFT_SRA) & bus.req_data[WIDTH-1];
            if (direct_done) begin
                rsp_data_q <= bus.req_data;
                rsp_err_q  <= (bus.req_op == SHIFT_RSVD);
            end
        end else if (state_q == ST_SHIFT) begin
            work_q <= step_out;
            rem_q  <= rem_nxt;
            if (last_step) begin
                rsp_data_q <= step_out;
                rsp_err_q  <= 1'b0;
            end
        end
    end

    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;
endmodule
